tdm_demux8: RTL and testbench
=============================

# tdm_demux8

Time-division demultiplexer: the receive-side counterpart of the 8:1 channel mux. It accepts a serial stream of samples, one channel per slot, with a start-of-frame marker on slot 0. It steers each sample into its channel register and presents all eight channels in parallel with a one-cycle frame-valid strobe. It sits after the TDM link and ahead of the per-channel consumers.

## Interface
- WIDTH, 8, bits per channel sample
- NUM_CH, 8, channels per frame; fixed at 8 (SEL_W = 3)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  sample present this cycle; always accepted, no backpressure
- in_sof  input  1  qualified by in_valid; the sample belongs to slot 0
- in_data  input  WIDTH  sample
- out_valid  output  1  one-cycle pulse; out_data holds a complete new frame
- out_data  output  NUM_CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]; ch0 is the LSBs
- slot  output  3  next expected slot index
- err  output  1  one-cycle pulse on a framing error (see Configuration)

## Operation
- States: HUNT (reset state) and COLLECT.
- HUNT:
  - in_valid & !in_sof: sample dropped; slot stays 0.
  - in_valid & in_sof: write shadow[0], slot←1, go to COLLECT.
- COLLECT, in_valid & !in_sof:
  - slot 1..6: write shadow[slot], slot←slot+1.
  - slot==7: write the sample into ch7. out_data←{sample, shadow[6:0]}. Pulse out_valid. slot←0. Stay in COLLECT.
  - slot==0: handled per Configuration.
- COLLECT, in_valid & in_sof, any slot: discard any partial frame, write shadow[0], slot←1. If slot≠0, this is an early SOF.
- in_valid low: no state change. Gaps of any length are allowed between samples.
- out_data changes only on a completed frame and holds its value otherwise. Shadow registers are internal and never visible.
- Reset values: out_valid=0, out_data=0, slot=0, err=0, shadow=0, state=HUNT.
- Reset mid-frame discards the partial frame. The first complete frame after reset must begin with a SOF.

## Timing
- All outputs are registered.
- out_valid and the new out_data appear in the cycle after the edge that accepts the slot-7 sample. Latency from last sample to frame valid is 1 cycle.
- Back-to-back frames (16 consecutive valid cycles) produce out_valid pulses exactly 8 cycles apart. No sample is lost at the wrap.
- err is asserted in the cycle after the offending sample's edge, for 1 cycle.
- A simultaneous SOF and slot-7 position is an early SOF: no out_valid, a new frame starts.

## Configuration
- TDM_DEMUX_SYNC_CHECK_EN defined:
  - A SOF early in COLLECT (slot≠0) pulses err.
  - In COLLECT at slot 0, in_valid & !in_sof pulses err, drops the sample, and returns to HUNT.
- Not defined:
  - err is tied to 0.
  - In COLLECT at slot 0, a non-SOF sample is accepted as slot 0 (free-running framing), with slot←1.
  - An early SOF silently restarts the frame.

## Structure
- Package tdm_demux_pkg:
  - NUM_CH and SEL_W localparams.
  - State enum {HUNT, COLLECT}.
- Sub-module demux_slot_dec: 3-bit slot plus enable to an 8-bit one-hot shadow write-enable. Instantiated once.

## Test plan
- Reset: rst_n=0 for 2 cycles while driving samples → out_valid=0, out_data=0, slot=0, err=0. The first non-SOF samples after reset are dropped.
- Full frame: SOF with 0x10, then 0x11..0x17 on consecutive cycles → one out_valid pulse the cycle after 0x17, and out_data=0x17161514_13121110.
- Gapped frame: same samples with in_valid low for 3 cycles after the 4th sample → slot holds 4 during the gap; the result is identical to the full-frame case.
- Early SOF (macro on): 5 samples, then SOF with 0xA0 → err pulses once, no out_valid; a following 7 samples complete a frame with ch0=0xA0.
- Missing SOF at wrap (macro on): after one complete frame, a non-SOF sample → err pulses, slot=0, state HUNT. With the macro off, the same stimulus gives no err and the sample lands in ch0.
- Back-to-back: 16 consecutive samples, SOF at 0 and 8 → two out_valid pulses exactly 8 cycles apart, each with the correct frame.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared constants and state encoding for the 8-slot TDM demultiplexer.
package tdm_demux_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {HUNT, COLLECT} state_t;
endpackage

// File: rtl/demux_slot_dec.sv
// Slot index plus enable to a one-hot write enable, one bit per channel.
module demux_slot_dec
  import tdm_demux_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  input  logic              en,
  output logic [NUM_CH-1:0] we
);
  always_comb begin
    we      = '0;
    we[sel] = en;
  end
endmodule

// File: rtl/tdm_demux8.sv
// TDM receive demux: serial slot samples to eight parallel channels per frame.
// Optional framing check enabled with `define TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux8
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]        slot,
  output logic                    err
);
  state_t                            state, state_n;
  logic   [SEL_W-1:0]                slot_n, dec_sel;
  logic                              dec_en;
  logic   [NUM_CH-1:0]               we;
  logic   [NUM_CH-2:0][WIDTH-1:0]    shadow;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  logic                              sync_err;
`endif

  always_comb begin
    state_n = state;
    slot_n  = slot;
    dec_en  = 1'b0;
    dec_sel = slot;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    sync_err = 1'b0;
`endif
    if (in_valid) begin
      if (in_sof) begin
        dec_en  = 1'b1;
        dec_sel = '0;
        slot_n  = SEL_W'(1);
        state_n = COLLECT;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        sync_err = (state == COLLECT) && (slot != '0);
`endif
      end else if (state == COLLECT) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        if (slot == '0) begin
          sync_err = 1'b1;
          state_n  = HUNT;
        end else begin
          dec_en = 1'b1;
          slot_n = slot + SEL_W'(1);
        end
`else
        // slot 0 without SOF is taken as free-running framing; 7 wraps to 0
        dec_en = 1'b1;
        slot_n = slot + SEL_W'(1);
`endif
      end
    end
  end

  demux_slot_dec u_dec (
    .sel (dec_sel),
    .en  (dec_en),
    .we  (we)
  );

  // we[7] marks the last sample: it goes straight to out_data, never to shadow
  for (genvar k = 0; k < NUM_CH-1; k++) begin : g_shadow
    always_ff @(posedge clk) begin
      if (!rst_n)     shadow[k] <= '0;
      else if (we[k]) shadow[k] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HUNT;
      slot      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      out_valid <= we[NUM_CH-1];
      if (we[NUM_CH-1]) out_data <= {in_data, shadow};
    end
  end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else        err <= sync_err;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized + directed bench for tdm_demux8 against a queue-based frame model.
module tb_tdm_demux8;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_sof;
  logic [7:0]  in_data;
  logic        out_valid, err;
  logic [63:0] out_data;
  logic [2:0]  slot;

  int checks = 0, errors = 0;
  int ncyc = 0, last_pulse = -1, prev_pulse = -1;

  // reference model: a frame is the queue of samples accepted since SOF
  bit [7:0]    q[$];
  bit          hunt;
  bit          e_valid, e_err;
  bit [63:0]   e_data;

  tdm_demux8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .slot(slot), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit s, input bit [7:0] d);
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (r) begin
      hunt = 1'b1; q.delete(); e_data = '0;
    end else if (v) begin
      if (s) begin
        if (!hunt && q.size() != 0) e_err = SYNC;
        q.delete(); q.push_back(d); hunt = 1'b0;
      end else if (!hunt) begin
        if (q.size() == 0 && SYNC) begin
          e_err = 1'b1; hunt = 1'b1;
        end else begin
          q.push_back(d);
          if (q.size() == 8) begin
            e_valid = 1'b1;
            for (int k = 0; k < 8; k++) e_data[k*8 +: 8] = q[k];
            q.delete();
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit s, input bit [7:0] d);
    rst_n = !r; in_valid = v; in_sof = s; in_data = d;
    model(r, v, s, d);
    @(negedge clk);
    ncyc++;
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("out_data", out_data, e_data);
    chk("slot", 64'(slot), 64'(q.size()));
    chk("err", 64'(err), 64'(e_err));
    if (out_valid) begin prev_pulse = last_pulse; last_pulse = ncyc; end
  endtask

  task automatic frame(input bit [7:0] base, input int gap_after);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, k == 0, base + 8'(k));
      if (k + 1 == gap_after)
        for (int g = 0; g < 3; g++) begin
          cyc(0, 0, 0, 8'hEE);
          chk("gap_slot", 64'(slot), 64'd4);
        end
    end
  endtask

  initial begin
    // reset while driving samples, then unsynchronized samples are dropped
    cyc(1, 1, 0, 8'h55);
    cyc(1, 1, 1, 8'h66);
    chk("rst_out_data", out_data, 64'h0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 8'h30 + 8'(k));
    chk("hunt_slot", 64'(slot), 64'd0);

    frame(8'h10, 0);
    chk("full_data", out_data, 64'h1716151413121110);
    cyc(0, 0, 0, 8'h00);
    chk("data_hold", out_data, 64'h1716151413121110);

    frame(8'h10, 4);
    chk("gapped_data", out_data, 64'h1716151413121110);

    // early SOF after 5 samples
    for (int k = 0; k < 5; k++) cyc(0, 1, k == 0, 8'h40 + 8'(k));
    cyc(0, 1, 1, 8'hA0);
    chk("early_err", 64'(err), 64'(SYNC));
    for (int k = 1; k < 8; k++) cyc(0, 1, 0, 8'hA0 + 8'(k));
    chk("early_ch0", 64'(out_data[7:0]), 64'hA0);

    // non-SOF sample at the wrap
    cyc(0, 1, 0, 8'h77);
    chk("wrap_err", 64'(err), 64'(SYNC));
    chk("wrap_slot", 64'(slot), SYNC ? 64'd0 : 64'd1);

    // back-to-back frames with SOF at sample 0 and 8
    for (int k = 0; k < 16; k++) cyc(0, 1, (k % 8) == 0, 8'hC0 + 8'(k));
    chk("b2b_gap", 64'(last_pulse - prev_pulse), 64'd8);
    chk("b2b_data", out_data, 64'hCFCECDCCCBCAC9C8);

    // randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      bit r, v, s;
      r = ($urandom % 300) == 0;
      v = ($urandom % 4) != 0;
      s = (($urandom % 20) == 0) || (q.size() == 0 && ($urandom % 3) != 0);
      cyc(r, v, s, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
